// File: rtl/bin2bcd_dabble.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Converts one BIN_WIDTH-bit unsigned value into DIGITS packed BCD digits,
// processing one input bit per clock, with valid/ready handshakes on both
// sides and a sticky overflow flag for values that do not fit in DIGITS.
module bin2bcd_dabble #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  busy
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Digits after the add-3 correction; the binary bits are never corrected.
    logic [BCD_W-1:0]     bcd_adj;
    // Bit leaving the top BCD digit during a shift; any 1 here means overflow.
    logic                 carry_out;

    // Add 3 to every digit that is 5 or more, all digits in parallel.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        carry_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {carry_out, bcd_d} = {bcd_adj, bin_q[BIN_WIDTH-1]};
                bin_d = bin_q << 1;
                ovf_d = ovf_q | carry_out;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_dabble.sv
// Self-checking bench for bin2bcd_dabble. Four instances cover the default
// configuration, a 4-bit/2-digit build, an 8-bit/2-digit build that can
// overflow, and the 1-bit/1-digit minimum. A selector routes the shared
// stimulus to one instance and muxes that instance's outputs for checking.
module tb_bin2bcd_dabble;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  bin_in;
    logic [1:0]  cur_sel;

    logic [3:0]  iv;
    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  bz;
    logic [3:0]  of;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [7:0]  bcd2;
    logic [3:0]  bcd3;

    logic        in_ready_m;
    logic        out_valid_m;
    logic        busy_m;
    logic        ovf_m;
    logic [11:0] bcd_m;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  value;
        logic [11:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [13];

    bin2bcd_dabble #(.BIN_WIDTH(8), .DIGITS(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .bin_in(bin_in), .out_valid(ov[0]), .out_ready(out_ready),
        .bcd_out(bcd0), .ovf(of[0]), .busy(bz[0])
    );

    bin2bcd_dabble #(.BIN_WIDTH(4), .DIGITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .bin_in(bin_in[3:0]), .out_valid(ov[1]), .out_ready(out_ready),
        .bcd_out(bcd1), .ovf(of[1]), .busy(bz[1])
    );

    bin2bcd_dabble #(.BIN_WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .bin_in(bin_in), .out_valid(ov[2]), .out_ready(out_ready),
        .bcd_out(bcd2), .ovf(of[2]), .busy(bz[2])
    );

    bin2bcd_dabble #(.BIN_WIDTH(1), .DIGITS(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .bin_in(bin_in[0:0]), .out_valid(ov[3]), .out_ready(out_ready),
        .bcd_out(bcd3), .ovf(of[3]), .busy(bz[3])
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the selected instance sees in_valid; out_ready is shared since
    // idle instances ignore it.
    always_comb begin
        iv = 4'b0000;
        iv[cur_sel] = in_valid;
    end

    // Route the selected instance's outputs onto common observation signals.
    always_comb begin
        in_ready_m  = ir[cur_sel];
        out_valid_m = ov[cur_sel];
        busy_m      = bz[cur_sel];
        ovf_m       = of[cur_sel];
        case (cur_sel)
            2'd0:    bcd_m = bcd0;
            2'd1:    bcd_m = {4'h0, bcd1};
            2'd2:    bcd_m = {4'h0, bcd2};
            default: bcd_m = {8'h00, bcd3};
        endcase
    end

    function automatic int latency(input logic [1:0] s);
        case (s)
            2'd1:    return 4;
            2'd3:    return 1;
            default: return 8;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then present one value for a single
    // accepting edge. Returns #1 after that edge.
    task automatic applyStimulus(input logic [1:0] s, input logic [7:0] value);
        int waited;
        cur_sel = s;
        @(negedge clk);
        waited = 0;
        while (!in_ready_m && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready_m) begin
            checkOutput("accept timeout", 32'(in_ready_m), 32'd1);
        end
        bin_in   = value;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full conversion: accept, check SHIFT-phase flags and exact latency,
    // check the result, then complete the output handshake.
    task automatic runConversion(input logic [1:0] s, input logic [7:0] value,
                                 input logic [11:0] exp_bcd, input logic exp_ovf);
        bit shift_ok;
        applyStimulus(s, value);
        shift_ok = 1'b1;
        for (int k = 0; k < latency(s); k++) begin
            if (!(busy_m && !in_ready_m && !out_valid_m)) shift_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("shift flags s%0d v%0d", s, value), 32'(shift_ok), 32'd1);
        checkOutput($sformatf("latency s%0d v%0d", s, value), 32'(out_valid_m), 32'd1);
        if (!exp_ovf) begin
            checkOutput($sformatf("bcd s%0d v%0d", s, value), 32'(bcd_m), 32'(exp_bcd));
        end
        checkOutput($sformatf("ovf s%0d v%0d", s, value), 32'(ovf_m), 32'(exp_ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput($sformatf("handshake s%0d v%0d", s, value),
                    32'({out_valid_m, in_ready_m}), 32'b01);
    endtask

    initial begin
        bit stable_ok;
        n_checks  = 0;
        n_fail    = 0;
        cur_sel   = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin_in    = 8'd0;
        rst_n     = 1'b0;

        vecs[0]  = '{2'd0, 8'd0,   12'h000, 1'b0};
        vecs[1]  = '{2'd0, 8'd9,   12'h009, 1'b0};
        vecs[2]  = '{2'd0, 8'd10,  12'h010, 1'b0};
        vecs[3]  = '{2'd0, 8'd255, 12'h255, 1'b0};
        vecs[4]  = '{2'd0, 8'd199, 12'h199, 1'b0};
        vecs[5]  = '{2'd0, 8'd128, 12'h128, 1'b0};
        vecs[6]  = '{2'd2, 8'd150, 12'h000, 1'b1};
        vecs[7]  = '{2'd2, 8'd99,  12'h099, 1'b0};
        vecs[8]  = '{2'd2, 8'd100, 12'h000, 1'b1};
        vecs[9]  = '{2'd2, 8'd255, 12'h000, 1'b1};
        vecs[10] = '{2'd2, 8'd0,   12'h000, 1'b0};
        vecs[11] = '{2'd3, 8'd0,   12'h000, 1'b0};
        vecs[12] = '{2'd3, 8'd1,   12'h001, 1'b0};

        // Reset state of every instance.
        #12;
        for (int s = 0; s < 4; s++) begin
            cur_sel = 2'(s);
            #1;
            checkOutput($sformatf("reset flags s%0d", s),
                        32'({out_valid_m, in_ready_m, busy_m, ovf_m}), 32'b0100);
            checkOutput($sformatf("reset bcd s%0d", s), 32'(bcd_m), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven conversions.
        foreach (vecs[i]) begin
            runConversion(vecs[i].sel, vecs[i].value, vecs[i].exp_bcd, vecs[i].exp_ovf);
        end

        // Full sweep of the 4-bit / 2-digit build.
        for (int v = 0; v < 16; v++) begin
            runConversion(2'd1, 8'(v), 12'(((v / 10) << 4) | (v % 10)), 1'b0);
        end

        // Backpressure: hold the result for 5 cycles while in_valid is asserted.
        applyStimulus(2'd0, 8'd77);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bp done", 32'(out_valid_m), 32'd1);
        stable_ok = 1'b1;
        bin_in    = 8'd33;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (!(out_valid_m && !in_ready_m && bcd_m == 12'h077)) stable_ok = 1'b0;
        end
        checkOutput("bp stable", 32'(stable_ok), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp release flags",
                    32'({out_valid_m, in_ready_m, busy_m}), 32'b010);
        checkOutput("bp held bcd", 32'(bcd_m), 32'h077);

        // Asynchronous reset in the middle of a conversion of 200.
        applyStimulus(2'd0, 8'd200);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst flags",
                    32'({out_valid_m, in_ready_m, busy_m}), 32'b010);
        checkOutput("async rst bcd", 32'(bcd_m), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runConversion(2'd0, 8'd42, 12'h042, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_dabble.md
Name: bin2bcd_dabble

Overview:
- Sequential, parametrised binary-to-BCD encoder using shift-and-add-3 (double dabble).
- Converts one BIN_WIDTH-bit unsigned value into DIGITS packed BCD digits, one bit per clock.
- Sits between binary datapath sources (counters, ALU results) and 7-segment or display drivers.
- Replaces the combinational single-digit encoder; adds multi-digit output, valid/ready handshake and an overflow flag.

Parameters:
- BIN_WIDTH, 8, width of binary input; legal range 1..32.
- DIGITS, 3, number of BCD output digits; legal range 1..10.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bin_in valid.
- in_ready  output  1  block can accept an input (IDLE only).
- bin_in  input  BIN_WIDTH  unsigned binary value.
- out_valid  output  1  bcd_out and ovf valid.
- out_ready  input  1  consumer accepts result.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- ovf  output  1  value exceeds 10^DIGITS-1; bcd_out is then invalid.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bcd_out=0, ovf=0, out_valid=0, busy=0, in_ready=1. Internal shift register and counter are cleared. An in-flight conversion is discarded; no output is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch bin_in into the shift register, clear the BCD register and the sticky ovf, set counter=BIN_WIDTH, go to SHIFT.
  - in_valid=0: remain in IDLE.
- SHIFT (busy=1, in_ready=0), one iteration per edge:
  - (a) Every 4-bit digit >=5 gets +3, all digits in parallel.
  - (b) Shift {bcd, bin} left by one.
  - (c) The bit shifted out of the BCD MSB is ORed into sticky ovf.
  - (d) counter-1.
  - The edge that performs the final iteration (counter==1) moves to DONE.
- Latency: out_valid rises exactly BIN_WIDTH edges after the accepting edge (8 for the defaults).
- DONE:
  - out_valid=1; bcd_out and ovf are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - bcd_out and ovf keep their last value in IDLE until the next accept.
- No new accept in the same cycle as a DONE handshake. Minimum spacing between accepts is BIN_WIDTH+2 cycles.
- in_valid while SHIFT or DONE is ignored (in_ready=0); the source must hold it.
- Overflow:
  - ovf=1 iff bin_in >= 10^DIGITS. Sticky ovf is exact because partial values only grow.
  - With the defaults, ovf can never assert.
- Arithmetic: all unsigned. The add-3 is applied only to digits, never to the remaining binary bits. Counter width is clog2(BIN_WIDTH+1).
- Boundary cases:
  - bin_in=0 gives all-zero BCD.
  - bin_in=2^BIN_WIDTH-1 must convert correctly when DIGITS is sufficient.
  - BIN_WIDTH=1 gives a 1-cycle SHIFT.

Test Plan:
- Defaults, accept bin_in=0, out_ready=1 -> out_valid exactly 8 edges after accept, bcd_out=12'h000, ovf=0; then 9 -> 12'h009; 10 -> 12'h010.
- Defaults, bin_in=255 and bin_in=199 -> bcd_out=12'h255 and 12'h199, ovf=0; in_ready=0 and busy=1 throughout the 8 SHIFT cycles.
- BIN_WIDTH=4, DIGITS=2, sweep 0..15 -> bcd_out 8'h00..8'h15 (e.g. 12 -> 8'h12), ovf=0 for every value.
- DIGITS=2, BIN_WIDTH=8:
  - bin_in=150 -> ovf=1.
  - bin_in=99 -> bcd_out=8'h99, ovf=0.
  - bin_in=100 -> ovf=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and bcd_out stable; in_valid pulsed meanwhile is not accepted.
  - Raise out_ready -> IDLE next edge, in_ready=1.
- Drop rst_n for 1 cycle mid-SHIFT (after 3 iterations of 200) -> out_valid=0, bcd_out=0, in_ready=1 immediately (async). The next input 42 converts to 12'h042 with no residue.
